// File: rtl/mux_channel_arbiter_if.sv
// Request/grant bundle between the two voice generators and the channel arbiter.
//   req1, req2 : channel output requests (level, driven by the voice generators)
//   sel        : 2:1 output mux select, 0 = Ch1, 1 = Ch2
//   gnt1, gnt2 : channel ownership indications
//   mute       : 1 = silence the output stage
// Modports: master = requester/output-stage side, slave = arbiter side.
interface mux_channel_arbiter_if;
  logic req1;
  logic req2;
  logic sel;
  logic gnt1;
  logic gnt2;
  logic mute;

  modport master (
    output req1,
    output req2,
    input  sel,
    input  gnt1,
    input  gnt2,
    input  mute
  );

  modport slave (
    input  req1,
    input  req2,
    output sel,
    output gnt1,
    output gnt2,
    output mute
  );
endinterface

// File: rtl/mux_channel_arbiter.sv
// Round-robin arbiter driving the select of the 2:1 output channel mux.
// An owner keeps the output for at least MIN_DWELL cycles before a waiting
// channel may preempt it, and every select change is wrapped in a GAP_CYCLES
// mute window so the mux never switches onto an audible output.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of mux_channel_arbiter_if (req1/req2 in; sel/gnt1/gnt2/mute out, all registered)
module mux_channel_arbiter #(
  parameter int unsigned MIN_DWELL  = 1000,
  parameter int unsigned GAP_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mux_channel_arbiter_if.slave bus
);

  localparam int unsigned DWELL_W = 16;
  localparam int unsigned GAP_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_d;
  logic                 tgt;          // GAP target: 0 = ch1, 1 = ch2
  logic                 tgt_d;
  logic                 last_served;  // 0 = ch1, 1 = ch2
  logic                 last_d;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [DWELL_W-1:0]   dwell_d;
  logic [GAP_W-1:0]     gap_cnt;
  logic [GAP_W-1:0]     gap_d;
  logic                 sel_d;
  logic                 gnt1_d;
  logic                 gnt2_d;
  logic                 mute_d;
  logic                 pick2;
  logic                 dwell_done;
  logic                 gap_done;

  // IDLE choice: ch2 if it is the only requester, or on a tie when ch1 was served last
  assign pick2      = bus.req2 & (~bus.req1 | ~last_served);
  assign dwell_done = (dwell_cnt == DWELL_W'(MIN_DWELL));
  assign gap_done   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // State register together with the registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tgt         <= 1'b0;
      last_served <= 1'b1;
      dwell_cnt   <= '0;
      gap_cnt     <= '0;
      bus.sel     <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.gnt2    <= 1'b0;
      bus.mute    <= 1'b1;
    end else begin
      state       <= state_d;
      tgt         <= tgt_d;
      last_served <= last_d;
      dwell_cnt   <= dwell_d;
      gap_cnt     <= gap_d;
      bus.sel     <= sel_d;
      bus.gnt1    <= gnt1_d;
      bus.gnt2    <= gnt2_d;
      bus.mute    <= mute_d;
    end
  end

  // Next-state logic; counters clear unless explicitly advanced
  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    last_d  = last_served;
    dwell_d = '0;
    gap_d   = '0;
    case (state)
      IDLE: begin
        if (bus.req1 | bus.req2) begin
          if (pick2 == bus.sel) begin
            state_d = pick2 ? OWN2 : OWN1;
            last_d  = pick2;
          end else begin
            state_d = GAP;
            tgt_d   = pick2;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          if (tgt ? bus.req2 : bus.req1) begin
            state_d = tgt ? OWN2 : OWN1;
            last_d  = tgt;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_cnt + GAP_W'(1);
        end
      end
      OWN1: begin
        if (!bus.req1 && bus.req2) begin
          state_d = GAP;
          tgt_d   = 1'b1;
        end else if (!bus.req1) begin
          state_d = IDLE;
        end else if (bus.req2 && dwell_done) begin
          state_d = GAP;
          tgt_d   = 1'b1;
        end else begin
          dwell_d = dwell_done ? dwell_cnt : dwell_cnt + DWELL_W'(1);
        end
      end
      OWN2: begin
        if (!bus.req2 && bus.req1) begin
          state_d = GAP;
          tgt_d   = 1'b0;
        end else if (!bus.req2) begin
          state_d = IDLE;
        end else if (bus.req1 && dwell_done) begin
          state_d = GAP;
          tgt_d   = 1'b0;
        end else begin
          dwell_d = dwell_done ? dwell_cnt : dwell_cnt + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state; sel only moves on GAP entry
  always_comb begin
    sel_d  = bus.sel;
    gnt1_d = 1'b0;
    gnt2_d = 1'b0;
    mute_d = 1'b1;
    case (state_d)
      OWN1: begin
        gnt1_d = 1'b1;
        mute_d = 1'b0;
        sel_d  = 1'b0;
      end
      OWN2: begin
        gnt2_d = 1'b1;
        mute_d = 1'b0;
        sel_d  = 1'b1;
      end
      GAP:     sel_d = tgt_d;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mux_channel_arbiter.sv
// Directed bench for mux_channel_arbiter with MIN_DWELL=8, GAP_CYCLES=2.
// Outputs are observed at the falling edge as {sel, gnt1, gnt2, mute}.
module tb_mux_channel_arbiter;

  localparam int unsigned MIN_DWELL  = 8;
  localparam int unsigned GAP_CYCLES = 2;

  localparam logic [3:0] O_IDLE0 = 4'b0001;  // sel=0, muted
  localparam logic [3:0] O_IDLE1 = 4'b1001;  // sel=1, muted (IDLE or GAP toward ch2)
  localparam logic [3:0] O_OWN1  = 4'b0100;
  localparam logic [3:0] O_OWN2  = 4'b1010;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic prev_sel;

  mux_channel_arbiter_if bus ();

  mux_channel_arbiter #(
    .MIN_DWELL  (MIN_DWELL),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [3:0] outs();
    return {bus.sel, bus.gnt1, bus.gnt2, bus.mute};
  endfunction

  // Advance one clock and check the outputs plus the global invariants
  task automatic cycle(input string tag, input logic [3:0] exp);
    @(negedge clk);
    check(tag, 32'(outs()), 32'(exp));
    check({tag, "_no_overlap"}, 32'(bus.gnt1 & bus.gnt2), 32'd0);
    if (bus.sel !== prev_sel) check({tag, "_sel_muted"}, 32'(bus.mute), 32'd1);
    prev_sel = bus.sel;
  endtask

  task automatic do_reset(input int n, input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(outs()), 32'(O_IDLE0));
      prev_sel = bus.sel;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    prev_sel = 1'b0;
    rst_n    = 1'b0;
    bus.req1 = 1'b1;
    bus.req2 = 1'b1;

    // 1. reset with both requesting, then ch1 granted first; 4. full round-robin
    do_reset(3, "rst_both_req");
    for (int i = 0; i < 9; i++) cycle("rr_own1", O_OWN1);
    for (int i = 0; i < 2; i++) cycle("rr_gap_to2", O_IDLE1);
    for (int i = 0; i < 9; i++) cycle("rr_own2", O_OWN2);
    for (int i = 0; i < 2; i++) cycle("rr_gap_to1", O_IDLE0);
    cycle("rr_back_own1", O_OWN1);

    // 5. release to IDLE, then a one-cycle req2 that is gone at gap end
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    cycle("rel_idle", O_IDLE0);
    bus.req2 = 1'b1;
    cycle("pulse_gap0", O_IDLE1);
    bus.req2 = 1'b0;
    cycle("pulse_gap1", O_IDLE1);
    cycle("pulse_idle", O_IDLE1);
    cycle("pulse_idle_hold", O_IDLE1);

    // 2. req1 only: one-cycle grant, held well past MIN_DWELL
    do_reset(1, "rst_t2");
    prev_sel = 1'b0;
    bus.req1 = 1'b1;
    cycle("req1_grant", O_OWN1);
    for (int i = 0; i < 12; i++) cycle("req1_hold", O_OWN1);
    bus.req1 = 1'b0;

    // 3. req2 only: select flips under mute, grant after GAP_CYCLES
    do_reset(1, "rst_t3");
    prev_sel = 1'b0;
    bus.req2 = 1'b1;
    cycle("req2_gap0", O_IDLE1);
    cycle("req2_gap1", O_IDLE1);
    cycle("req2_grant", O_OWN2);
    for (int i = 0; i < 12; i++) cycle("req2_hold", O_OWN2);
    bus.req2 = 1'b0;
    cycle("req2_rel", O_IDLE1);

    // 6. reset in the middle of a gap
    do_reset(1, "rst_t6a");
    prev_sel = 1'b0;
    bus.req2 = 1'b1;
    cycle("midgap_gap0", O_IDLE1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midgap_rst", 32'(outs()), 32'(O_IDLE0));
    check("midgap_state", 32'(dut.state), 32'd0);
    prev_sel = bus.sel;
    rst_n    = 1'b1;
    bus.req1 = 1'b1;
    cycle("midgap_own1", O_OWN1);
    cycle("midgap_own1b", O_OWN1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
